// File: rtl/sccb_init_sequencer_if.sv
// Controller-side bus of the SCCB init sequencer.
// Byte pushes, write kick-off and controller status.
interface sccb_init_sequencer_if;
  logic       store_data_o;
  logic [7:0] data_o;
  logic       send_data_o;
  logic       ctrl_init_done_i;
  logic       device_ready_i;
  logic       error_i;

  modport master (
    output store_data_o,
    output data_o,
    output send_data_o,
    input  ctrl_init_done_i,
    input  device_ready_i,
    input  error_i
  );

  modport slave (
    input  store_data_o,
    input  data_o,
    input  send_data_o,
    output ctrl_init_done_i,
    output device_ready_i,
    output error_i
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Walks a ROM of {reg_addr, reg_val} words and writes each one
// through an I2C/SCCB controller, with delay/end markers and retries.
module sccb_init_sequencer #(
  parameter int          ADDR_BYTES   = 1,
  parameter int          ROM_AW       = 8,
  parameter int          DELAY_CYCLES = 2_700_000,
  parameter int          MAX_RETRIES  = 3,
  parameter int          AUTO_START   = 1,
  parameter logic [7:0]  DELAY_VAL    = 8'hF0,
  parameter logic [7:0]  END_VAL      = 8'hFF,
  localparam int         DW           = 8 * ADDR_BYTES + 8,
  localparam int         RW           = $clog2(MAX_RETRIES + 1)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start_i,
  sccb_init_sequencer_if.master ctrl,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic [DW-1:0]         rom_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [RW-1:0]         retry_cnt_o
);

  localparam int DCW = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
  localparam int BW  = $clog2(ADDR_BYTES + 1);

  localparam logic [DCW-1:0] DLOAD = DCW'(DELAY_CYCLES - 1);
  localparam logic [BW-1:0]  BLAST = BW'(ADDR_BYTES);
  localparam logic [RW-1:0]  RMAX  = RW'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, FETCH, CHECK, LOAD, SEND,
    GUARD, WAIT_TX, DELAY, DONE, FAIL
  } state_t;

  state_t            state, state_n;
  logic [ROM_AW-1:0] addr_n;
  logic [RW-1:0]     retry_n;
  logic [DCW-1:0]    dcnt, dcnt_n;
  logic [BW-1:0]     bidx, bidx_n;
  logic              gcnt, gcnt_n;
  logic              boot;

  logic              mark;
  logic              last;
  logic [DW-1:0]     sh;
  logic [7:0]        cur_byte;

  assign mark     = &rom_data_i[DW-1:8];
  assign last     = &rom_addr_o;
  assign sh       = rom_data_i << (8 * bidx);
  assign cur_byte = sh[DW-1 -: 8];

  // State and counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      rom_addr_o  <= '0;
      retry_cnt_o <= '0;
      dcnt        <= '0;
      bidx        <= '0;
      gcnt        <= 1'b0;
      boot        <= 1'b1;
    end else begin
      state       <= state_n;
      rom_addr_o  <= addr_n;
      retry_cnt_o <= retry_n;
      dcnt        <= dcnt_n;
      bidx        <= bidx_n;
      gcnt        <= gcnt_n;
      boot        <= 1'b0;
    end
  end

  // Next-state, address, retry and counter logic
  always_comb begin
    state_n = state;
    addr_n  = rom_addr_o;
    retry_n = retry_cnt_o;
    dcnt_n  = dcnt;
    bidx_n  = bidx;
    gcnt_n  = gcnt;
    unique case (state)
      IDLE: begin
        if (start_i || ((AUTO_START != 0) && boot)) begin
          state_n = WAIT_RDY;
          addr_n  = '0;
          retry_n = '0;
        end
      end
      WAIT_RDY: begin
        if (ctrl.ctrl_init_done_i && ctrl.device_ready_i)
          state_n = FETCH;
      end
      FETCH: state_n = CHECK;
      CHECK: begin
        if (mark && rom_data_i[7:0] == END_VAL) begin
          state_n = DONE;
        end else if (mark && rom_data_i[7:0] == DELAY_VAL) begin
          state_n = DELAY;
          dcnt_n  = DLOAD;
        end else begin
          state_n = LOAD;
          bidx_n  = '0;
        end
      end
      LOAD: begin
        if (bidx == BLAST) state_n = SEND;
        else bidx_n = bidx + 1'b1;
      end
      SEND: begin
        state_n = GUARD;
        gcnt_n  = 1'b0;
      end
      GUARD: begin
        if (gcnt) state_n = WAIT_TX;
        else gcnt_n = 1'b1;
      end
      WAIT_TX: begin
        if (ctrl.error_i) begin
          if (retry_cnt_o == RMAX) begin
            state_n = FAIL;
          end else begin
            retry_n = retry_cnt_o + 1'b1;
            state_n = WAIT_RDY;
          end
        end else if (ctrl.device_ready_i) begin
          retry_n = '0;
          if (last) begin
            state_n = DONE;
          end else begin
            addr_n  = rom_addr_o + 1'b1;
            state_n = FETCH;
          end
        end
      end
      DELAY: begin
        if (dcnt == '0) begin
          if (last) begin
            state_n = DONE;
          end else begin
            addr_n  = rom_addr_o + 1'b1;
            state_n = WAIT_RDY;
          end
        end else begin
          dcnt_n = dcnt - 1'b1;
        end
      end
      DONE, FAIL: begin
        if (start_i) begin
          state_n = WAIT_RDY;
          addr_n  = '0;
          retry_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ctrl.store_data_o = (state == LOAD);
  assign ctrl.send_data_o  = (state == SEND);
  assign ctrl.data_o       = (state == LOAD) ? cur_byte : 8'h00;

  assign busy_o = !(state == IDLE || state == DONE || state == FAIL);
  assign done_o = (state == DONE);
  assign fail_o = (state == FAIL);

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: directed table, random ROMs with a
// transaction-level model, reset abort and a 2-byte-address instance.
module tb_sccb_init_sequencer;

  logic clk;
  logic rst_n;
  logic start0, start1;

  logic [3:0]  ra0;
  logic [15:0] rd0;
  logic        busy0, done0, fail0;
  logic [1:0]  rc0;

  logic [2:0]  ra1;
  logic [23:0] rd1;
  logic        busy1, done1, fail1;
  logic [0:0]  rc1;

  sccb_init_sequencer_if c0();
  sccb_init_sequencer_if c1();

  sccb_init_sequencer #(
    .ADDR_BYTES(1), .ROM_AW(4), .DELAY_CYCLES(10),
    .MAX_RETRIES(2), .AUTO_START(1)
  ) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start0),
    .ctrl(c0), .rom_addr_o(ra0), .rom_data_i(rd0),
    .busy_o(busy0), .done_o(done0), .fail_o(fail0),
    .retry_cnt_o(rc0)
  );

  sccb_init_sequencer #(
    .ADDR_BYTES(2), .ROM_AW(3), .DELAY_CYCLES(4),
    .MAX_RETRIES(1), .AUTO_START(0)
  ) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start_i(start1),
    .ctrl(c1), .rom_addr_o(ra1), .rom_data_i(rd1),
    .busy_o(busy1), .done_o(done1), .fail_o(fail1),
    .retry_cnt_o(rc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom0 [16];
  logic [23:0] rom1 [8];
  bit          plan [64];
  assign rd0 = rom0[ra0];
  assign rd1 = rom1[ra1];

  int nvec, nmis;
  int base;
  logic [19:0] log_q [$];
  int viol;

  logic [15:0] exp_q [$];
  bit exp_done, exp_fail;
  int exp_addr, exp_retry;

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    logic [7:0]  errs;
    bit          poke;
    int          ntx;
    bit          done;
    bit          fail;
    int          addr;
    int          retry;
    int          busy;
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller stand-in: collects bytes, answers each write after a
  // random latency, with the error outcome taken from plan[].
  initial begin
    logic [15:0] cur;
    logic [3:0]  nb;
    int lat, idx;
    bit pend;
    cur = '0; nb = '0; lat = 0; pend = 0; viol = 0;
    c0.device_ready_i = 1'b1;
    c0.error_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (c0.store_data_o || c0.send_data_o) viol++;
        cur = '0; nb = '0; lat = 0;
        c0.device_ready_i = 1'b1;
        c0.error_i = 1'b0;
      end else begin
        if (c0.store_data_o && c0.send_data_o) viol++;
        if (c0.store_data_o) begin
          cur = {cur[7:0], c0.data_o};
          nb++;
          c0.error_i = 1'b0;
        end
        if (c0.send_data_o) begin
          log_q.push_back({nb, cur});
          idx = log_q.size() - 1 - base;
          pend = (idx >= 0 && idx < 64) ? plan[idx] : 1'b0;
          cur = '0; nb = '0;
          lat = $urandom_range(1, 4);
          c0.device_ready_i = 1'b0;
          c0.error_i = 1'b0;
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            c0.device_ready_i = 1'b1;
            c0.error_i = pend;
          end
        end
      end
    end
  end

  // Transaction-level reference: which writes occur and how it ends.
  task automatic model();
    int a, k, r;
    bit fin;
    logic [15:0] w;
    exp_q.delete();
    a = 0; k = 0; r = 0; fin = 0;
    exp_done = 0; exp_fail = 0;
    while (!fin) begin
      w = rom0[a];
      if (w == 16'hFFFF) begin
        exp_done = 1; fin = 1;
      end else if (w == 16'hFFF0) begin
        if (a == 15) begin exp_done = 1; fin = 1; end
        else a++;
      end else begin
        exp_q.push_back(w);
        if (plan[k]) begin
          if (r == 2) begin exp_fail = 1; fin = 1; end
          else r++;
        end else begin
          r = 0;
          if (a == 15) begin exp_done = 1; fin = 1; end
          else a++;
        end
        k++;
      end
    end
    exp_addr = a;
    exp_retry = r;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) rom0[i] = 16'hFFFF;
    rom0[0] = v.w0; rom0[1] = v.w1;
    rom0[2] = v.w2; rom0[3] = v.w3;
    for (int i = 0; i < 64; i++) plan[i] = 1'b0;
    for (int i = 0; i < 8; i++) plan[i] = v.errs[i];
  endtask

  task automatic run(input bit auto_go, input bit poke,
                     output int busy_cyc);
    bit to;
    base = log_q.size();
    if (!auto_go) start0 = 1'b1;
    busy_cyc = 0;
    to = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0 && !auto_go) begin
        start0 = 1'b0;
        chk("restart", {30'd0, done0, busy0}, 32'd1);
      end
      if (poke && c == 6) start0 = 1'b1;
      if (poke && c == 7) start0 = 1'b0;
      if (busy0) busy_cyc++;
      if (done0 || fail0) begin
        to = 0;
        break;
      end
    end
    if (to) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic compare(input string tag, input int ntx, input bit d,
                         input bit f, input int addr, input int retry);
    chk({tag, " ntx"}, log_q.size() - base, ntx);
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
      chk({tag, " txn"}, {12'd0, log_q[base + i]}, {16'd2, exp_q[i]});
    chk({tag, " done"}, {31'd0, done0}, {31'd0, d});
    chk({tag, " fail"}, {31'd0, fail0}, {31'd0, f});
    chk({tag, " addr"}, {28'd0, ra0}, addr);
    chk({tag, " retry"}, {30'd0, rc0}, retry);
  endtask

  initial begin
    int bc, sc, cyc, snd_cyc, nsend;
    logic [7:0] q1 [$];
    int st [$];
    nvec = 0; nmis = 0; base = 0;
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    c0.ctrl_init_done_i = 1'b1;
    c1.ctrl_init_done_i = 1'b1;
    c1.device_ready_i = 1'b1;
    c1.error_i = 1'b0;
    for (int i = 0; i < 8; i++) rom1[i] = 24'hFFFFFF;
    rom1[0] = 24'h300882;

    tab[0] = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 8'h00, 0,
               2, 1, 0, 2, 0, 0};
    tab[1] = '{16'hFFF0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00, 0,
               0, 1, 0, 1, 0, 16};
    tab[2] = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 0,
               3, 0, 1, 0, 2, 0};
    tab[3] = '{16'h1280, 16'h3344, 16'hFFFF, 16'hFFFF, 8'h01, 0,
               3, 1, 0, 2, 0, 0};
    tab[4] = '{16'h1280, 16'h3344, 16'hFFFF, 16'hFFFF, 8'h06, 0,
               4, 1, 0, 2, 0, 0};
    tab[5] = '{16'h1280, 16'h3344, 16'hFFFF, 16'hFFFF, 8'h0E, 0,
               4, 0, 1, 1, 2, 0};
    tab[6] = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 8'h00, 1,
               2, 1, 0, 2, 0, 0};
    tab[7] = '{16'h1280, 16'hFFF0, 16'h5566, 16'hFFFF, 8'h00, 0,
               2, 1, 0, 3, 0, 0};

    load_vec(tab[0]);
    repeat (3) @(negedge clk);
    chk("reset outs", {c0.store_data_o, c0.send_data_o, c0.data_o,
        busy0, done0, fail0, ra0, rc0}, 32'd0);
    chk("u1 reset", {busy1, done1, fail1, ra1, rc1}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load_vec(tab[i]);
      run(i == 0, tab[i].poke, bc);
      model();
      compare($sformatf("vec%0d", i), tab[i].ntx, tab[i].done,
              tab[i].fail, tab[i].addr, tab[i].retry);
      if (tab[i].busy != 0)
        chk($sformatf("vec%0d busy", i), bc, tab[i].busy);
    end

    for (int n = 0; n < 30; n++) begin
      int r;
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 15);
        if (r == 0 && i < 15) rom0[i] = 16'hFFF0;
        else if (r == 1) rom0[i] = 16'hFFFF;
        else rom0[i] = {8'($urandom_range(0, 254)),
                        8'($urandom_range(0, 255))};
      end
      for (int i = 0; i < 64; i++) plan[i] = ($urandom_range(0, 3) == 0);
      run(1'b0, 1'b0, bc);
      model();
      compare($sformatf("rnd%0d", n), exp_q.size(), exp_done,
              exp_fail, exp_addr, exp_retry);
    end

    load_vec(tab[0]);
    base = log_q.size();
    start0 = 1'b1;
    sc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c0.store_data_o) sc++;
      if (sc == 2) break;
    end
    chk("rst store2", sc, 2);
    rst_n = 1'b0;
    #1;
    chk("rst abort", {c0.store_data_o, c0.send_data_o, c0.data_o,
        busy0, done0, fail0, ra0, rc0}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 1'b0, bc);
    model();
    compare("rst rerun", 2, 1'b1, 1'b0, 2, 0);

    chk("u1 idle", {31'd0, busy1}, 32'd0);
    start1 = 1'b1;
    snd_cyc = -1;
    nsend = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (c1.store_data_o) begin
        q1.push_back(c1.data_o);
        st.push_back(c);
      end
      if (c1.send_data_o) begin
        nsend++;
        if (snd_cyc < 0) snd_cyc = c;
      end
      if (done1 || fail1) break;
    end
    chk("u1 nstore", q1.size(), 3);
    if (q1.size() == 3) begin
      chk("u1 bytes", {8'd0, q1[0], q1[1], q1[2]}, 32'h300882);
      chk("u1 contig", st[2] - st[0], 2);
      chk("u1 send cyc", snd_cyc, st[2] + 1);
    end
    chk("u1 nsend", nsend, 1);
    chk("u1 done", {done1, fail1, ra1}, {27'd0, 5'b10001});

    chk("strobe rules", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
